// File: rtl/spi_cmd_arbiter.sv
// spi_cmd_arbiter
//   Two-requester round-robin arbiter that sequences one SPI command at a
//   time through the config decoder (SETUP / WAIT_CFG) and the shift engine
//   (RUN), then returns a one-cycle response tagged with the requester id.
//
//   Optional feature: define SPI_ARB_TIMEOUT_EN to add a watchdog that aborts
//   WAIT_CFG / RUN after TIMEOUT_CYCLES cycles with resp_err=1, resp_data=0.
//   With the macro undefined there is no counter, resp_err is tied 0 and the
//   FSM waits indefinitely for the decoder and shift engine.
module spi_cmd_arbiter #(
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [74:0] req0_desc,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [74:0] req1_desc,
   output logic [7:0]  dec_command,
   output logic [2:0]  dec_commandtype,
   output logic [31:0] dec_address,
   output logic [31:0] dec_datain,
   output logic        setup_start,
   input  logic        build_done,
   input  logic        counters_done,
   output logic        xfer_start,
   input  logic        xfer_done,
   input  logic [31:0] rx_data,
   output logic        resp_valid,
   output logic        resp_id,
   output logic [31:0] resp_data,
   output logic        resp_err,
   output logic        busy
);

   localparam logic [1:0] IDLE     = 2'd0;
   localparam logic [1:0] SETUP    = 2'd1;
   localparam logic [1:0] WAIT_CFG = 2'd2;
   localparam logic [1:0] RUN      = 2'd3;

   logic [1:0]  state;
   logic [1:0]  state_nxt;
   logic [74:0] hold_desc;     // descriptor of the transaction in flight
   logic        hold_id;       // requester that owns hold_desc
   logic        last_grant;    // requester granted on the most recent accept
   logic        grant;
   logic        accept;
   logic        flag_build;    // sticky build_done seen in WAIT_CFG
   logic        flag_cnt;      // sticky counters_done seen in WAIT_CFG
   logic        cfg_done;
   logic        run_first;     // high during the first RUN cycle only
   logic        xfer_fin;      // shift engine completed this cycle
   logic        timeout;       // watchdog expired this cycle (0 if disabled)
   logic        abort;         // watchdog abort that actually takes effect

   // Arbitration: a lone requester wins; on a tie the one not granted last wins.
   always_comb begin
      grant = 1'b0;
      if (req0_valid && req1_valid)
         grant = ~last_grant;
      else if (req1_valid)
         grant = 1'b1;
   end

   // Ready only in IDLE; gated by rst so every output reads 0 during reset.
   assign req0_ready = ~rst & (state == IDLE) & req0_valid & ~grant;
   assign req1_ready = ~rst & (state == IDLE) & req1_valid &  grant;
   assign accept     = req0_ready | req1_ready;

   // Decoder handshakes may land in the same cycle or in different cycles.
   assign cfg_done = (flag_build | build_done) & (flag_cnt | counters_done);
   assign xfer_fin = (state == RUN) & xfer_done;

   // A watchdog expiry loses to a completion arriving in the same cycle.
   assign abort = timeout & ~((state == WAIT_CFG) ? cfg_done : xfer_fin);

`ifdef SPI_ARB_TIMEOUT_EN
   localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   logic [CW-1:0] wd_cnt;
   logic          wd_active;
   logic          wd_enter;

   assign wd_active = (state == WAIT_CFG) | (state == RUN);
   assign wd_enter  = (state_nxt != state) &
                      ((state_nxt == WAIT_CFG) | (state_nxt == RUN));
   assign timeout   = wd_active & (wd_cnt == CW'(TIMEOUT_CYCLES - 1));

   // Watchdog counter: restarts on each entry to WAIT_CFG / RUN.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         wd_cnt <= '0;
      else if (wd_enter)
         wd_cnt <= '0;
      else if (wd_active)
         wd_cnt <= wd_cnt + 1'b1;
   end

   // Error flag rides along with each response.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         resp_err <= 1'b0;
      else if (xfer_fin)
         resp_err <= 1'b0;
      else if (abort)
         resp_err <= 1'b1;
   end
`else
   assign timeout  = 1'b0;
   assign resp_err = 1'b0;
`endif

   // Next-state logic for the command sequencer.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:     if (accept) state_nxt = SETUP;
         SETUP:    state_nxt = WAIT_CFG;
         WAIT_CFG: begin
            if (cfg_done)
               state_nxt = RUN;
            else if (abort)
               state_nxt = IDLE;
         end
         RUN: begin
            if (xfer_fin || abort)
               state_nxt = IDLE;
         end
         default:  state_nxt = IDLE;
      endcase
   end

   // State register; reset aborts any transaction silently.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Holding registers and round-robin pointer update only on accept.
   // last_grant resets to 1 so req0 wins the first tie.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold_desc  <= '0;
         hold_id    <= 1'b0;
         last_grant <= 1'b1;
      end else if (accept) begin
         hold_desc  <= grant ? req1_desc : req0_desc;
         hold_id    <= grant;
         last_grant <= grant;
      end
   end

   // Sticky decoder-done flags: cleared on SETUP entry, set only in WAIT_CFG.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         flag_build <= 1'b0;
         flag_cnt   <= 1'b0;
      end else if (accept) begin
         flag_build <= 1'b0;
         flag_cnt   <= 1'b0;
      end else if (state == WAIT_CFG) begin
         if (build_done)    flag_build <= 1'b1;
         if (counters_done) flag_cnt   <= 1'b1;
      end
   end

   // Marks the first RUN cycle so xfer_start is a single-cycle pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         run_first <= 1'b0;
      else
         run_first <= (state != RUN) & (state_nxt == RUN);
   end

   // Response: one-cycle valid pulse; data and id hold until the next one.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         resp_valid <= 1'b0;
         resp_id    <= 1'b0;
         resp_data  <= '0;
      end else begin
         resp_valid <= 1'b0;
         if (xfer_fin) begin
            resp_valid <= 1'b1;
            resp_id    <= hold_id;
            resp_data  <= rx_data;
         end else if (abort) begin
            resp_valid <= 1'b1;
            resp_id    <= hold_id;
            resp_data  <= '0;
         end
      end
   end

   assign setup_start     = (state == SETUP);
   assign xfer_start      = (state == RUN) & run_first;
   assign busy            = (state != IDLE);
   assign dec_command     = hold_desc[74:67];
   assign dec_commandtype = hold_desc[66:64];
   assign dec_address     = hold_desc[63:32];
   assign dec_datain      = hold_desc[31:0];

endmodule
